// File: rtl/mmio_data_responder_pkg.sv
// Shared constants for mmio_data_responder: MMIO register offsets, TIMER_CTRL
// bit positions, status bit positions and the countdown-timer state encoding.
package mmio_data_responder_pkg;

    // Byte offsets within the 0x20-byte MMIO page.
    localparam logic [4:0] OFS_CYCLE_LO     = 5'h00;
    localparam logic [4:0] OFS_CYCLE_HI     = 5'h04;
    localparam logic [4:0] OFS_TEST_STATUS  = 5'h08;
    localparam logic [4:0] OFS_TEST_VALUE   = 5'h0C;
    localparam logic [4:0] OFS_TIMER_LOAD   = 5'h10;
    localparam logic [4:0] OFS_TIMER_CTRL   = 5'h14;
    localparam logic [4:0] OFS_FAULT_ADDR   = 5'h18;
    localparam logic [4:0] OFS_FAULT_STATUS = 5'h1C;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ      = 2;

    localparam int STATUS_DONE = 0;
    localparam int STATUS_PASS = 1;

    localparam int FAULT_OOR      = 0;
    localparam int FAULT_MISALIGN = 1;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/mmio_data_responder_timer.sv
// One-shot / periodic countdown timer behind TIMER_LOAD and TIMER_CTRL,
// with a sticky write-1-to-clear interrupt.
module mmio_timer
    import mmio_data_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_we,
    input  logic        ctrl_we,
    input  logic [31:0] wr_data,
    output logic [31:0] load_value,
    output logic [2:0]  ctrl_value,
    output logic        irq
);

    timer_state_t state_reg, state_next;
    logic [31:0]  count_reg, count_next;
    logic [31:0]  load_reg;
    logic         en_reg, periodic_reg;
    logic         irq_reg, irq_next;
    logic         expire;
    logic         periodic_eff;
    logic         stop_req;
    logic         start_req;

    // A CTRL write landing on the same cycle as expiry decides what happens next.
    assign periodic_eff = ctrl_we ? wr_data[CTRL_PERIODIC] : periodic_reg;
    assign stop_req     = ctrl_we && !wr_data[CTRL_EN];
    assign start_req    = ctrl_we && wr_data[CTRL_EN] && (load_reg != 32'd0);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        irq_next   = irq_reg;
        expire     = 1'b0;
        case (state_reg)
            TMR_IDLE: begin
                if (start_req) begin
                    state_next = TMR_RUN;
                    count_next = load_reg;
                end
            end
            TMR_RUN: begin
                if (count_reg <= 32'd1) begin
                    expire     = 1'b1;
                    count_next = 32'd0;
                    if (stop_req) begin
                        state_next = TMR_IDLE;
                    end else if (periodic_eff && (load_reg != 32'd0)) begin
                        count_next = load_reg;
                    end else begin
                        state_next = TMR_EXPIRED;
                    end
                end else if (stop_req) begin
                    state_next = TMR_IDLE;
                end else begin
                    count_next = count_reg - 32'd1;
                end
            end
            TMR_EXPIRED: begin
                if (start_req) begin
                    state_next = TMR_RUN;
                    count_next = load_reg;
                end else if (ctrl_we) begin
                    state_next = TMR_IDLE;
                end
            end
            default: state_next = TMR_IDLE;
        endcase
        // Set has priority over a simultaneous clear.
        if (ctrl_we && wr_data[CTRL_IRQ]) begin
            irq_next = 1'b0;
        end
        if (expire) begin
            irq_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= TMR_IDLE;
            count_reg    <= 32'd0;
            load_reg     <= 32'd0;
            en_reg       <= 1'b0;
            periodic_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            irq_reg   <= irq_next;
            if (load_we) begin
                load_reg <= wr_data;
            end
            if (ctrl_we) begin
                en_reg       <= wr_data[CTRL_EN];
                periodic_reg <= wr_data[CTRL_PERIODIC];
            end
        end
    end

    assign load_value = load_reg;
    assign ctrl_value = {irq_reg, periodic_reg, en_reg};
    assign irq        = irq_reg;

endmodule

// File: rtl/mmio_data_responder.sv
// Data-memory responder: word RAM plus an MMIO page (cycle counter, test mailbox,
// countdown timer). Define MEM_FAULT_EN to enable out-of-range/misaligned fault capture.
module mmio_data_responder
    import mmio_data_responder_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_sig,
    input  logic [31:0] wr_data,
    input  logic [31:0] addr,
    output logic [31:0] rd_data,
    output logic        test_done,
    output logic        test_pass,
    output logic        timer_irq,
    output logic        fault
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] mem [RAM_WORDS];

    logic        ram_hit;
    logic        mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [4:0]  reg_ofs;
    logic        commit;
    logic        fault_now;
    logic [31:0] fault_addr_value;
    logic [1:0]  fault_status_value;

    logic [63:0] cycle_reg;
    logic [1:0]  test_status_reg;
    logic [31:0] test_value_reg;

    logic [31:0] timer_load;
    logic [2:0]  timer_ctrl;
    logic        timer_load_we;
    logic        timer_ctrl_we;

    assign ram_hit  = addr < RAM_BYTES;
    assign mmio_hit = addr[31:5] == MMIO_BASE[31:5];
    assign ram_idx  = addr[AW+1:2];
    assign reg_ofs  = {addr[4:2], 2'b00};
    assign commit   = wr_sig && !fault_now;

    always_ff @(posedge clk) begin
        if (commit && ram_hit) begin
            mem[ram_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_reg       <= 64'd0;
            test_status_reg <= 2'b00;
            test_value_reg  <= 32'd0;
        end else begin
            cycle_reg <= cycle_reg + 64'd1;
            if (commit && mmio_hit && reg_ofs == OFS_TEST_STATUS) begin
                test_status_reg <= wr_data[1:0];
            end
            if (commit && mmio_hit && reg_ofs == OFS_TEST_VALUE) begin
                test_value_reg <= wr_data;
            end
        end
    end

    assign timer_load_we = commit && mmio_hit && (reg_ofs == OFS_TIMER_LOAD);
    assign timer_ctrl_we = commit && mmio_hit && (reg_ofs == OFS_TIMER_CTRL);

    mmio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_we    (timer_load_we),
        .ctrl_we    (timer_ctrl_we),
        .wr_data    (wr_data),
        .load_value (timer_load),
        .ctrl_value (timer_ctrl),
        .irq        (timer_irq)
    );

`ifdef MEM_FAULT_EN
    logic [31:0] prev_addr_reg;
    logic [31:0] fault_addr_reg;
    logic [1:0]  fault_status_reg;
    logic        fault_reg;
    logic        oor_evt;
    logic        misalign_evt;

    // A read is only counted when the address moves, so a held address faults once.
    assign oor_evt      = !ram_hit && !mmio_hit && (wr_sig || (addr != prev_addr_reg));
    assign misalign_evt = wr_sig && (addr[1:0] != 2'b00);
    assign fault_now    = oor_evt || misalign_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_addr_reg    <= 32'd0;
            fault_addr_reg   <= 32'd0;
            fault_status_reg <= 2'b00;
            fault_reg        <= 1'b0;
        end else begin
            prev_addr_reg <= addr;
            if (fault_now) begin
                fault_reg                        <= 1'b1;
                fault_status_reg[FAULT_OOR]      <= fault_status_reg[FAULT_OOR] | oor_evt;
                fault_status_reg[FAULT_MISALIGN] <= fault_status_reg[FAULT_MISALIGN] | misalign_evt;
                if (!fault_reg) begin
                    fault_addr_reg <= addr;
                end
            end
        end
    end

    assign fault_addr_value   = fault_addr_reg;
    assign fault_status_value = fault_status_reg;
    assign fault              = fault_reg;
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs   = ^addr[1:0];
    assign fault_now          = 1'b0;
    assign fault_addr_value   = 32'd0;
    assign fault_status_value = 2'b00;
    assign fault              = 1'b0;
`endif

    always_comb begin
        rd_data = 32'd0;
        if (ram_hit) begin
            rd_data = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_ofs)
                OFS_CYCLE_LO:     rd_data = cycle_reg[31:0];
                OFS_CYCLE_HI:     rd_data = cycle_reg[63:32];
                OFS_TEST_STATUS:  rd_data = {30'd0, test_status_reg};
                OFS_TEST_VALUE:   rd_data = test_value_reg;
                OFS_TIMER_LOAD:   rd_data = timer_load;
                OFS_TIMER_CTRL:   rd_data = {29'd0, timer_ctrl};
                OFS_FAULT_ADDR:   rd_data = fault_addr_value;
                OFS_FAULT_STATUS: rd_data = {30'd0, fault_status_value};
                default:          rd_data = 32'd0;
            endcase
        end
    end

    assign test_done = test_status_reg[STATUS_DONE];
    assign test_pass = test_status_reg[STATUS_PASS];

endmodule

// File: tb/tb_mmio_data_responder.sv
// Scoreboard bench for mmio_data_responder: expectations are queued with each
// stimulus and compared when the DUT output is sampled on the falling edge.
module tb_mmio_data_responder;
    import mmio_data_responder_pkg::*;

    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam logic [31:0] RAM_BYTES = 32'd4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_sig;
    logic [31:0] wr_data;
    logic [31:0] addr;
    logic [31:0] rd_data;
    logic        test_done;
    logic        test_pass;
    logic        timer_irq;
    logic        fault;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    mmio_data_responder dut (
        .clk       (clk),
        .reset     (reset),
        .wr_sig    (wr_sig),
        .wr_data   (wr_data),
        .addr      (addr),
        .rd_data   (rd_data),
        .test_done (test_done),
        .test_pass (test_pass),
        .timer_irq (timer_irq),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            check_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Callers sit on a falling edge; the store commits on the next rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_sig  = 1'b1;
        @(negedge clk);
        wr_sig  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        addr   = a;
        wr_sig = 1'b0;
        #1;
        sb_check(rd_data);
    endtask

    task automatic out_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    initial begin
        reset   = 1'b1;
        wr_sig  = 1'b0;
        wr_data = 32'd0;
        addr    = 32'd0;
        repeat (2) @(negedge clk);

        out_check("reset_outputs", {28'd0, test_done, test_pass, timer_irq, fault}, 32'd0);
        read_check("reset_cycle_lo", BASE + 32'h00, 32'd0);

        reset = 1'b0;
        repeat (10) @(negedge clk);
        read_check("cycle_lo_10", BASE + 32'h00, 32'd10);
        read_check("cycle_hi", BASE + 32'h04, 32'd0);

        do_write(32'h40, 32'hDEAD_BEEF);
        read_check("ram_40", 32'h40, 32'hDEAD_BEEF);
        do_write(32'h44, 32'h1234_5678);
        read_check("ram_44", 32'h44, 32'h1234_5678);
        read_check("ram_40_again", 32'h40, 32'hDEAD_BEEF);
        do_write(RAM_BYTES - 32'd4, 32'hA5A5_5A5A);
        read_check("ram_last_word", RAM_BYTES - 32'd4, 32'hA5A5_5A5A);
        read_check("ram_past_end", RAM_BYTES, 32'd0);
        read_check("unmapped_read", 32'h2000_0000, 32'd0);

        do_write(BASE + 32'h08, 32'h3);
        out_check("mailbox_done_pass", {30'd0, test_done, test_pass}, 32'd3);
        read_check("status_reg", BASE + 32'h08, 32'd3);
        do_write(BASE + 32'h08, 32'h1);
        out_check("mailbox_done_only", {30'd0, test_done, test_pass}, 32'd2);
        do_write(BASE + 32'h0C, 32'hCAFE_F00D);
        read_check("test_value", BASE + 32'h0C, 32'hCAFE_F00D);
        do_write(BASE + 32'h04, 32'hFFFF_FFFF);
        read_check("cycle_hi_ro", BASE + 32'h04, 32'd0);

        // One-shot: irq rises on the fifth rising edge after the CTRL write.
        do_write(BASE + 32'h10, 32'd5);
        read_check("timer_load", BASE + 32'h10, 32'd5);
        do_write(BASE + 32'h14, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            sb_push($sformatf("oneshot_irq_c%0d", k), (k == 5) ? 32'd1 : 32'd0);
            @(negedge clk);
            sb_check({31'd0, timer_irq});
        end
        out_check("oneshot_state", 32'(dut.u_timer.state_reg), 32'(TMR_EXPIRED));
        read_check("oneshot_ctrl", BASE + 32'h14, 32'h5);
        do_write(BASE + 32'h14, 32'h4);
        out_check("irq_cleared", {31'd0, timer_irq}, 32'd0);
        out_check("idle_after_clear", 32'(dut.u_timer.state_reg), 32'(TMR_IDLE));

        do_write(BASE + 32'h10, 32'd0);
        do_write(BASE + 32'h14, 32'h1);
        repeat (3) @(negedge clk);
        out_check("zero_load_idle", 32'(dut.u_timer.state_reg), 32'(TMR_IDLE));
        out_check("zero_load_no_irq", {31'd0, timer_irq}, 32'd0);

        // Periodic: expiries three cycles apart; clear lands between them.
        do_write(BASE + 32'h10, 32'd3);
        do_write(BASE + 32'h14, 32'h3);
        for (int k = 1; k <= 3; k++) begin
            sb_push($sformatf("periodic_irq_c%0d", k), (k == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
            sb_check({31'd0, timer_irq});
        end
        do_write(BASE + 32'h14, 32'h7);
        out_check("periodic_irq_clr", {31'd0, timer_irq}, 32'd0);
        for (int k = 5; k <= 6; k++) begin
            sb_push($sformatf("periodic_irq_c%0d", k), (k == 6) ? 32'd1 : 32'd0);
            @(negedge clk);
            sb_check({31'd0, timer_irq});
        end
        out_check("periodic_running", 32'(dut.u_timer.state_reg), 32'(TMR_RUN));
        @(negedge clk);
        reset = 1'b1;
        #1;
        out_check("midreset_irq", {31'd0, timer_irq}, 32'd0);
        out_check("midreset_state", 32'(dut.u_timer.state_reg), 32'(TMR_IDLE));
        out_check("midreset_mailbox", {30'd0, test_done, test_pass}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef MEM_FAULT_EN
        do_write(32'h4, 32'h1111_1111);
        out_check("no_fault_aligned", {31'd0, fault}, 32'd0);
        do_write(32'h6, 32'hFFFF_0000);
        out_check("fault_flag", {31'd0, fault}, 32'd1);
        read_check("fault_addr", BASE + 32'h18, 32'h6);
        read_check("fault_status", BASE + 32'h1C, 32'h2);
        read_check("ram_4_unchanged", 32'h4, 32'h1111_1111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_data_responder.md
Name: mmio_data_responder

Overview:
- Responder end of the CPU data-memory interface (`wr_sig`, `wr_data`, `addr`, `rd_data`). It sits in place of the plain data RAM beside `cpu` and `rom` in the top level and in benches.
- Decodes the address into a word RAM plus a small MMIO page:
  - free-running 64-bit cycle counter
  - test-status mailbox, so benches check pass/fail from ports instead of peeking CPU registers
  - one-shot/periodic countdown timer with a sticky interrupt

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h1000_0000, byte base of the MMIO page (page size 0x20).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_sig  in  1  write strobe from CPU; a store of `wr_data` to `addr` commits on this cycle's rising edge.
- wr_data  in  32  store data.
- addr  in  32  byte address; bits [1:0] ignored for decode.
- rd_data  out  32  read data, combinational from `addr`, valid the same cycle.
- test_done  out  1  mailbox done flag.
- test_pass  out  1  mailbox pass flag.
- timer_irq  out  1  sticky timer interrupt.
- fault  out  1  sticky access fault (only meaningful with the optional feature).

Behaviour:
- Reset state: all outputs 0; cycle counter 0; mailbox 0; timer IDLE with LOAD=0, CTRL=0; fault registers 0. RAM contents are not reset.
- Reads are combinational, with zero wait states:
  - RAM hit: `rd_data` = mem[addr[31:2] - 0].
  - MMIO hit: register value.
  - Otherwise: 0.
- Writes commit on the rising edge when `wr_sig`=1. A write that does not hit RAM or MMIO is ignored.
- MMIO map (offsets from MMIO_BASE):
  - 0x00 CYCLE_LO, RO.
  - 0x04 CYCLE_HI, RO.
  - 0x08 TEST_STATUS, RW: bit0=done, bit1=pass.
  - 0x0C TEST_VALUE, RW, 32-bit.
  - 0x10 TIMER_LOAD, RW.
  - 0x14 TIMER_CTRL, RW: bit0=en, bit1=periodic, bit2=irq (write 1 to clear; reads sticky state).
  - 0x18 FAULT_ADDR, RO.
  - 0x1C FAULT_STATUS, RO: bit0 out-of-range, bit1 misaligned.
  - Writes to RO offsets are ignored.
- Cycle counter:
  - Increments by 1 every clock after reset deassertion; 64-bit wrap to 0.
  - Reads are live, with no snapshot; software reads HI, LO, HI.
- Mailbox: `test_done`/`test_pass` reflect TEST_STATUS[0]/[1] from the cycle after the write.
- Timer FSM, states IDLE, RUN, EXPIRED:
  - IDLE -> RUN: on a CTRL write with en=1 and LOAD != 0. The count is loaded from LOAD.
  - RUN: count decrements by 1 per cycle.
  - On the cycle count goes 1 -> 0:
    - `timer_irq` sets (visible the next cycle).
    - periodic=1: count reloads from LOAD and the FSM stays in RUN.
    - periodic=0: the FSM goes to EXPIRED.
  - EXPIRED -> IDLE: on any CTRL write with en=0. EXPIRED -> RUN: on a CTRL write with en=1.
  - A CTRL write with en=0 in any state returns the FSM to IDLE. The count holds; the irq is unaffected unless bit2=1 is written.
  - A CTRL write with en=1 and LOAD=0 leaves the FSM in IDLE.
  - A LOAD write during RUN changes only the reload value, not the current count.
- Simultaneous events:
  - Irq-clear write in the same cycle as expiry: set wins, and the irq stays 1.
  - CTRL write in the same cycle as a periodic reload: the written CTRL governs the next state.
- Reset mid-operation: asynchronous return to the reset state. Any in-flight store is dropped.

Optional Feature:
- Macro: MEM_FAULT_EN.
- With the macro defined, an access raises a fault when either:
  - `wr_sig`=1 and `addr` is outside both regions, or `addr[1:0]` != 0; or
  - `addr` is outside both regions and the access is a read. A read here is any cycle with `wr_sig`=0 and `addr` differing from the previous cycle.
- On a fault:
  - FAULT_ADDR captures the first faulting `addr`; later faults do not overwrite it.
  - FAULT_STATUS bits set.
  - `fault` is asserted sticky until reset.
  - A faulting write is not committed.
- Without the macro: no fault logic; `fault` is tied 0; 0x18/0x1C read 0; misaligned accesses use addr[31:2].

Decomposition:
- `parameters.vh` holds MMIO offset constants, the TIMER_CTRL bit indices, and the timer state encodings (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2).
- One sub-module is natural: `mmio_timer`, covering the LOAD/CTRL registers, the FSM, the down-counter and the irq. The top level keeps the RAM, address decode, cycle counter, mailbox and fault logic.

Test Plan:
- Write 0xDEADBEEF to 0x40, then read 0x40 -> `rd_data`=0xDEADBEEF in the same cycle. Read 0x2000_0000 -> 0.
- Release reset, wait 10 cycles, read MMIO_BASE+0x00 -> 10 (±1 per the bench's sampling edge); CYCLE_HI=0.
- Write 0x3 to MMIO_BASE+0x08 -> `test_done`=1 and `test_pass`=1 the next cycle. Write 0x1 -> `test_pass`=0.
- LOAD=5, CTRL=0x1 -> `timer_irq` rises exactly 5 cycles after the CTRL write and the FSM is EXPIRED. Write CTRL=0x4 -> irq=0.
- LOAD=3, CTRL=0x3 (periodic) -> irq sets at cycle 3. Clear it -> it sets again 3 cycles after the prior expiry. Assert reset mid-count -> irq=0 and the FSM is IDLE immediately.
- With MEM_FAULT_EN: a store to 0x0000_0006 -> `fault`=1, FAULT_ADDR=0x6, FAULT_STATUS=0x2, and the word at 0x4 is unchanged.
